// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the lapido pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;
  localparam int unsigned PC_WIDTH = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } pctl_state_e;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Event and control bundle between the pipeline stages and pipeline_ctrl.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic                load_use_hazard;
  logic                is_jump;
  logic [PC_WIDTH-1:0] jump_addr;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_addr;
  logic                halt;
  logic                resume;

  logic                stall_pipeline;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_addr;
  logic                flush_if;
  logic                flush_id;
  logic                halted;
  logic [1:0]          state;

  modport master (
    output load_use_hazard, is_jump, jump_addr, branch_taken, branch_addr, halt, resume,
    input  stall_pipeline, redirect, redirect_addr, flush_if, flush_id, halted, state
  );

  modport slave (
    input  load_use_hazard, is_jump, jump_addr, branch_taken, branch_addr, halt, resume,
    output stall_pipeline, redirect, redirect_addr, flush_if, flush_id, halted, state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: prioritises branch > jump > halt > load-use and
// owns the multi-cycle stall/flush counter and the HALT/resume handshake.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);

  pctl_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        halted_q;
  logic        redirect;

  assign redirect          = bus.branch_taken | (bus.is_jump & (state_q == RUN));
  assign bus.redirect      = redirect;
  assign bus.redirect_addr = bus.branch_taken ? bus.branch_addr : bus.jump_addr;
  assign bus.flush_if      = redirect;
  assign bus.flush_id      = redirect | (state_q == FLUSH);
  assign bus.stall_pipeline = !redirect &
      ((state_q == STALL) | (state_q == HALT) |
       ((state_q == RUN) & (bus.halt | bus.load_use_hazard)));
  assign bus.halted        = halted_q;
  assign bus.state         = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (bus.halt) begin
          state_d = HALT;
        end else if (bus.load_use_hazard && (STALL_CYCLES > 1)) begin
          // Detection cycle is the first bubble, so only STALL_CYCLES-1 remain.
          state_d = STALL;
          cnt_d   = STALL_LOAD;
        end
      end
      STALL, FLUSH: begin
        if (bus.branch_taken) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (cnt_q <= 4'd1) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      HALT: begin
        if (bus.branch_taken) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (bus.resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALT);
    end
  end

endmodule
